clock_set_ctrl: RTL and testbench

Time-of-day controller for the clock.
- Holds the hours, minutes and seconds registers and advances them on a 1 Hz tick.
- Sequences a user set mode driven by two push-button inputs.
- Sits between the tick generator and the display decoders, and replaces free-running cascaded counters with one sequenced, settable datapath.

---
 rtl/clock_pkg.sv | 14 +
 rtl/clock_set_ctrl_btn_edge.sv | 72 +++++++
 rtl/clock_set_ctrl.sv | 135 +++++++++++++
 tb/tb_clock_set_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared field widths, wrap constants and FSM state encodings for the time-of-day controller.
package clock_pkg;

    localparam int unsigned HR_W    = 5;
    localparam int unsigned MS_W    = 6;
    localparam int unsigned SEC_MAX = 60;
    localparam int unsigned MIN_MAX = 60;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] SET_HOUR = 2'd1;
    localparam logic [1:0] SET_MIN  = 2'd2;
    localparam logic [1:0] SET_SEC  = 2'd3;

endpackage

// File: rtl/clock_set_ctrl_btn_edge.sv
// Button level to single-clk event detector; with CLOCK_SET_AUTO_REPEAT_EN it also emits
// held-button repeat events after REPEAT_DLY cycles, then every REPEAT_PER cycles.
module btn_edge
`ifdef CLOCK_SET_AUTO_REPEAT_EN
#(
    parameter bit          REPEAT_EN  = 1'b0,
    parameter int unsigned REPEAT_DLY = 50_000_000,
    parameter int unsigned REPEAT_PER = 12_500_000
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    input  logic hold_en_i,
    input  logic clr_i,
`endif
    output logic evt_o
);

    logic prev_q;
    logic evt_q;
    logic evt_d;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int unsigned CNT_W = $clog2(REPEAT_DLY + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rep_c;

    // After the first repeat the counter is rewound so later repeats are REPEAT_PER apart.
    always_comb begin
        cnt_d = cnt_q;
        rep_c = 1'b0;
        if (!REPEAT_EN || !btn_i || !hold_en_i || clr_i) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(REPEAT_DLY - 1)) begin
            rep_c = 1'b1;
            cnt_d = CNT_W'(REPEAT_DLY - REPEAT_PER);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign evt_d = (btn_i & ~prev_q) | rep_c;
`else
    assign evt_d = btn_i & ~prev_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b0;
            evt_q  <= 1'b0;
        end else begin
            prev_q <= btn_i;
            evt_q  <= evt_d;
        end
    end

    assign evt_o = evt_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-of-day counter with button-driven set mode (hours, minutes, seconds).
// Optional macro CLOCK_SET_AUTO_REPEAT_EN enables hold-to-repeat on the increment button.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned HOURS_MAX  = 24,
    parameter int unsigned REPEAT_DLY = 50_000_000,
    parameter int unsigned REPEAT_PER = 12_500_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick_1hz,
    input  logic            btn_mode,
    input  logic            btn_inc,
    output logic [HR_W-1:0] hours,
    output logic [MS_W-1:0] minutes,
    output logic [MS_W-1:0] seconds,
    output logic [1:0]      mode,
    output logic            blink,
    output logic            day_pulse
);

    if (!(HOURS_MAX == 12 || HOURS_MAX == 24)) begin : g_bad_hours_max
        $error("clock_set_ctrl: HOURS_MAX must be 12 or 24");
    end
    if (REPEAT_PER == 0 || REPEAT_DLY < REPEAT_PER) begin : g_bad_repeat
        $error("clock_set_ctrl: need 0 < REPEAT_PER <= REPEAT_DLY");
    end

    logic [1:0]      state_q, state_d;
    logic [HR_W-1:0] hr_q, hr_d;
    logic [MS_W-1:0] min_q, min_d;
    logic [MS_W-1:0] sec_q, sec_d;
    logic            blink_q, blink_d;
    logic            day_q, day_d;
    logic            mode_evt;
    logic            inc_evt;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    logic state_chg_c;
    assign state_chg_c = (state_d != state_q);

    btn_edge #(.REPEAT_EN(1'b0), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_mode_edge (
        .clk(clk), .reset(reset), .btn_i(btn_mode),
        .hold_en_i(1'b0), .clr_i(1'b0), .evt_o(mode_evt)
    );
    btn_edge #(.REPEAT_EN(1'b1), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_inc_edge (
        .clk(clk), .reset(reset), .btn_i(btn_inc),
        .hold_en_i(state_q != RUN), .clr_i(state_chg_c), .evt_o(inc_evt)
    );
`else
    btn_edge u_mode_edge (.clk(clk), .reset(reset), .btn_i(btn_mode), .evt_o(mode_evt));
    btn_edge u_inc_edge  (.clk(clk), .reset(reset), .btn_i(btn_inc),  .evt_o(inc_evt));
`endif

    // Counting, setting and mode sequencing; all carries settle in the tick clk.
    always_comb begin
        state_d = state_q;
        hr_d    = hr_q;
        min_d   = min_q;
        sec_d   = sec_q;
        blink_d = blink_q;
        day_d   = 1'b0;
        case (state_q)
            RUN: begin
                blink_d = 1'b0;
                if (tick_1hz) begin
                    if (sec_q == MS_W'(SEC_MAX - 1)) begin
                        sec_d = '0;
                        if (min_q == MS_W'(MIN_MAX - 1)) begin
                            min_d = '0;
                            if (hr_q == HR_W'(HOURS_MAX - 1)) begin
                                hr_d  = '0;
                                day_d = 1'b1;
                            end else begin
                                hr_d = hr_q + HR_W'(1);
                            end
                        end else begin
                            min_d = min_q + MS_W'(1);
                        end
                    end else begin
                        sec_d = sec_q + MS_W'(1);
                    end
                end
                if (mode_evt) begin
                    state_d = SET_HOUR;
                end
            end
            default: begin
                if (tick_1hz) begin
                    blink_d = ~blink_q;
                end
                if (mode_evt) begin
                    state_d = (state_q == SET_SEC) ? RUN : state_q + 2'd1;
                end else if (inc_evt) begin
                    case (state_q)
                        SET_HOUR: hr_d  = (hr_q == HR_W'(HOURS_MAX - 1)) ? '0 : hr_q + HR_W'(1);
                        SET_MIN:  min_d = (min_q == MS_W'(MIN_MAX - 1)) ? '0 : min_q + MS_W'(1);
                        SET_SEC:  sec_d = '0;
                        default:  ;
                    endcase
                end
            end
        endcase
        if (state_d != state_q) begin
            blink_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            hr_q    <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            blink_q <= 1'b0;
            day_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hr_q    <= hr_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            blink_q <= blink_d;
            day_q   <= day_d;
        end
    end

    assign hours     = hr_q;
    assign minutes   = min_q;
    assign seconds   = sec_q;
    assign mode      = state_q;
    assign blink     = blink_q;
    assign day_pulse = day_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: a small time-of-day model pushes expected snapshots
// into a scoreboard queue, which are popped and compared against the DUT outputs.
module tb_clock_set_ctrl;

    localparam int HOURS_MAX = 24;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       blink;
    logic       day_pulse;

    clock_set_ctrl #(.HOURS_MAX(HOURS_MAX), .REPEAT_DLY(10), .REPEAT_PER(4)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .hours(hours), .minutes(minutes), .seconds(seconds), .mode(mode),
        .blink(blink), .day_pulse(day_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    h;
        int    m;
        int    s;
        int    md;
        int    bl;
        int    dp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_h = 0, m_m = 0, m_s = 0, m_md = 0, m_bl = 0;

    task automatic cmp(input string tag, input string fld, input logic [31:0] got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s.%s: got %0d expected %0d", tag, fld, got, exp);
        end
    endtask

    task automatic expect_now(input string tag, input int dp);
        exp_t e;
        e.tag = tag; e.h = m_h; e.m = m_m; e.s = m_s; e.md = m_md; e.bl = m_bl; e.dp = dp;
        sb_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            cmp("scoreboard", "underflow", 32'd1, 0);
        end else begin
            e = sb_q.pop_front();
            cmp(e.tag, "hours",     32'(hours),     e.h);
            cmp(e.tag, "minutes",   32'(minutes),   e.m);
            cmp(e.tag, "seconds",   32'(seconds),   e.s);
            cmp(e.tag, "mode",      32'(mode),      e.md);
            cmp(e.tag, "blink",     32'(blink),     e.bl);
            cmp(e.tag, "day_pulse", 32'(day_pulse), e.dp);
        end
    endtask

    task automatic model_tick();
        if (m_md == 0) begin
            m_s++;
            if (m_s == 60) begin
                m_s = 0;
                m_m++;
                if (m_m == 60) begin
                    m_m = 0;
                    m_h = (m_h + 1) % HOURS_MAX;
                end
            end
        end else begin
            m_bl ^= 1;
        end
    endtask

    task automatic do_tick();
        @(negedge clk) tick_1hz = 1'b1;
        @(negedge clk) tick_1hz = 1'b0;
        model_tick();
    endtask

    task automatic press_mode();
        @(negedge clk) btn_mode = 1'b1;
        repeat (2) @(negedge clk);
        btn_mode = 1'b0;
        repeat (2) @(negedge clk);
        m_md = (m_md + 1) % 4;
        m_bl = 0;
    endtask

    task automatic model_inc();
        case (m_md)
            1: m_h = (m_h + 1) % HOURS_MAX;
            2: m_m = (m_m + 1) % 60;
            3: m_s = 0;
            default: ;
        endcase
    endtask

    task automatic press_inc();
        @(negedge clk) btn_inc = 1'b1;
        repeat (2) @(negedge clk);
        btn_inc = 1'b0;
        repeat (2) @(negedge clk);
        model_inc();
    endtask

    task automatic press_both();
        @(negedge clk) begin
            btn_mode = 1'b1;
            btn_inc  = 1'b1;
        end
        repeat (2) @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (2) @(negedge clk);
        m_md = (m_md + 1) % 4;
        m_bl = 0;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        expect_now("reset", 0);
        check_out();

        reset = 1'b1;
        @(negedge clk);
        repeat (61) do_tick();
        expect_now("run61", 0);
        check_out();

        // Reset dropped between edges must clear everything without a clock.
        @(negedge clk) tick_1hz = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        m_h = 0; m_m = 0; m_s = 0; m_md = 0; m_bl = 0;
        expect_now("async_rst", 0);
        check_out();
        tick_1hz = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(negedge clk);

        repeat (37) do_tick();
        expect_now("run37", 0);
        check_out();

        press_mode();
        expect_now("set_hour", 0);
        check_out();
        repeat (25) press_inc();
        repeat (3) do_tick();
        expect_now("hour_wrap", 0);
        check_out();

        press_mode();
        repeat (61) press_inc();
        repeat (2) do_tick();
        expect_now("min_wrap", 0);
        check_out();

        press_mode();
        expect_now("set_sec", 0);
        check_out();
        press_inc();
        expect_now("sec_clear", 0);
        check_out();
        do_tick();
        press_mode();
        expect_now("back_run", 0);
        check_out();
        do_tick();
        expect_now("resume", 0);
        check_out();

        press_mode();
        repeat (4) press_inc();
        expect_now("hour5", 0);
        check_out();
        press_both();
        expect_now("mode_wins", 0);
        check_out();

        repeat (59) press_inc();
        expect_now("min_zero", 0);
        check_out();

        @(negedge clk) btn_inc = 1'b1;
        repeat (30) @(negedge clk);
        btn_inc = 1'b0;
        repeat (3) @(negedge clk);
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        m_m = 6;
`else
        m_m = 1;
`endif
        expect_now("hold_inc", 0);
        check_out();

        press_mode();
        press_inc();
        press_mode();
        press_mode();
        n = (HOURS_MAX - 1) - m_h;
        repeat (n) press_inc();
        press_mode();
        n = 59 - m_m;
        repeat (n) press_inc();
        press_mode();
        press_mode();
        repeat (59) do_tick();
        expect_now("pre_wrap", 0);
        check_out();

        @(negedge clk) tick_1hz = 1'b1;
        @(negedge clk) tick_1hz = 1'b0;
        model_tick();
        expect_now("day_wrap", 1);
        check_out();
        @(negedge clk);
        expect_now("day_once", 0);
        check_out();

        cmp("scoreboard", "drained", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
